// File: rtl/image_leakyrelu_pipe.sv
// Per-lane zero-point / activation / saturate pipeline for quantised image lanes.
// Three valid/ready stages that stall together; config travels with each beat.
module image_leakyrelu_pipe #(
  parameter int PICTURE_NUM = 1,
  parameter int CH_OUT_NUM  = 8,
  parameter int DATA_W      = 8,
  parameter int SCALE_W     = 18,
  parameter int SHIFT       = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [PICTURE_NUM*CH_OUT_NUM*DATA_W-1:0]  in_data,
  input  logic                                      in_last,
  input  logic [1:0]                                mode_in,
  input  logic [DATA_W-1:0]                         zero_in,
  input  logic [SCALE_W-1:0]                        scale_in,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [PICTURE_NUM*CH_OUT_NUM*DATA_W-1:0]  out_data,
  output logic                                      out_last
);

  localparam int LANES = PICTURE_NUM * CH_OUT_NUM;
  localparam int D_W   = DATA_W + 1;
  localparam int P_W   = DATA_W + SCALE_W + 2;
  localparam int R_W   = P_W + 1;

  localparam logic signed [P_W-1:0] ROUND = {{(P_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [R_W-1:0] MAXV  = {{(R_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic adv;

  logic v1_q, v2_q, v3_q;
  logic [1:0]         mode1_q;
  logic [DATA_W-1:0]  zero1_q, zero2_q;
  logic [SCALE_W-1:0] scale1_q;
  logic               last1_q, last2_q, last3_q;

  logic [LANES*D_W-1:0]    d1_d, d1_q;
  logic [LANES*P_W-1:0]    a2_d, a2_q;
  logic [LANES*DATA_W-1:0] o3_d, o3_q;

  // The whole pipe moves only when the output slot is free or being drained.
  assign adv      = !v3_q || out_ready;
  assign in_ready = adv;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [D_W-1:0] s1_diff;
      logic signed [D_W-1:0] s2_d;
      logic signed [P_W-1:0] s2_prod;
      logic signed [P_W-1:0] s2_rnd;
      logic signed [P_W-1:0] s2_leaky;
      logic signed [P_W-1:0] s2_act;
      logic signed [P_W-1:0] s3_a;
      logic signed [R_W-1:0] s3_sum;
      logic [DATA_W-1:0]     s3_sat;

      // Stage 1: remove zero point.
      assign s1_diff = $signed({1'b0, in_data[gi*DATA_W +: DATA_W]})
                     - $signed({1'b0, zero_in});
      assign d1_d[gi*D_W +: D_W] = s1_diff;

      // Stage 2: activation; leaky slope result rounds half-up via floor shift.
      assign s2_d     = d1_q[gi*D_W +: D_W];
      assign s2_prod  = P_W'(s2_d) * P_W'($signed({1'b0, scale1_q}));
      assign s2_rnd   = s2_prod + ROUND;
      assign s2_leaky = s2_rnd >>> SHIFT;

      always_comb begin
        s2_act = P_W'(s2_d);
        if (s2_d[D_W-1]) begin
          case (mode1_q)
            2'd1:    s2_act = '0;
            2'd2:    s2_act = s2_leaky;
            default: s2_act = P_W'(s2_d);
          endcase
        end
      end
      assign a2_d[gi*P_W +: P_W] = s2_act;

      // Stage 3: restore zero point and clamp to the unsigned lane range.
      assign s3_a   = a2_q[gi*P_W +: P_W];
      assign s3_sum = R_W'(s3_a) + R_W'($signed({1'b0, zero2_q}));

      always_comb begin
        s3_sat = s3_sum[DATA_W-1:0];
        if (s3_sum[R_W-1]) begin
          s3_sat = '0;
        end else if (s3_sum > MAXV) begin
          s3_sat = '1;
        end
      end
      assign o3_d[gi*DATA_W +: DATA_W] = s3_sat;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      mode1_q  <= '0;
      zero1_q  <= '0;
      scale1_q <= '0;
      last1_q  <= 1'b0;
      zero2_q  <= '0;
      last2_q  <= 1'b0;
      last3_q  <= 1'b0;
      d1_q     <= '0;
      a2_q     <= '0;
      o3_q     <= '0;
    end else if (adv) begin
      v1_q     <= in_valid;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      mode1_q  <= mode_in;
      zero1_q  <= zero_in;
      scale1_q <= scale_in;
      last1_q  <= in_last;
      zero2_q  <= zero1_q;
      last2_q  <= last1_q;
      last3_q  <= last2_q;
      d1_q     <= d1_d;
      a2_q     <= a2_d;
      o3_q     <= o3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_data  = o3_q;
  assign out_last  = last3_q;

endmodule

// File: tb/tb_image_leakyrelu_pipe.sv
// Randomised and directed bench for image_leakyrelu_pipe with an in-bench
// arithmetic reference model and a per-cycle output scoreboard.
module tb_image_leakyrelu_pipe;

  localparam int PN = 2;
  localparam int CN = 4;
  localparam int DW = 8;
  localparam int SW = 18;
  localparam int SH = 16;
  localparam int LN = PN * CN;
  localparam int LW = LN * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic [1:0]    mode_in = '0;
  logic [DW-1:0] zero_in = '0;
  logic [SW-1:0] scale_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [LW-1:0] out_data;
  logic          out_last;

  image_leakyrelu_pipe #(
    .PICTURE_NUM(PN), .CH_OUT_NUM(CN), .DATA_W(DW), .SCALE_W(SW), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mode_in(mode_in), .zero_in(zero_in), .scale_in(scale_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input bit ok, input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic with explicit floor division.
  function automatic int ref_lane(input int x, input int mode, input int z, input longint scale);
    longint d, a, num, den, r, top;
    d = x - z;
    a = d;
    if (d < 0 && mode == 1) begin
      a = 0;
    end else if (d < 0 && mode == 2) begin
      den = longint'(1) << SH;
      num = d * scale + den / 2;
      a = num / den;
      if ((num % den) != 0 && num < 0) a = a - 1;
    end
    r   = a + z;
    top = (longint'(1) << DW) - 1;
    if (r < 0) r = 0;
    if (r > top) r = top;
    return int'(r);
  endfunction

  function automatic logic [LW-1:0] ref_beat(input logic [LW-1:0] data, input logic [1:0] mode,
                                             input logic [DW-1:0] z, input logic [SW-1:0] s);
    logic [LW-1:0] res;
    int v;
    res = '0;
    for (int k = 0; k < LN; k++) begin
      v = ref_lane(int'(data[k*DW +: DW]), int'(mode), int'(z), longint'(s));
      res[k*DW +: DW] = v[DW-1:0];
    end
    return res;
  endfunction

  typedef struct {
    logic [LW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mb;
  logic          stall_q = 1'b0;
  logic [LW-1:0] hold_data;
  logic          hold_last;

  // Scoreboard: handshakes are evaluated at the negedge preceding the edge that takes them.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        check(out_valid && out_data == hold_data && out_last == hold_last,
              "stall_hold", out_data, hold_data);
      if (exp_q.size() == 3 && !out_ready)
        check(!in_ready, "full_in_ready", LW'(in_ready), '0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", out_data, '0);
        end else begin
          mb = exp_q.pop_front();
          check(out_data == mb.data, "beat_data", out_data, mb.data);
          check(out_last == mb.last, "beat_last", LW'(out_last), LW'(mb.last));
        end
      end
      if (in_valid && in_ready) begin
        mb.data = ref_beat(in_data, mode_in, zero_in, scale_in);
        mb.last = in_last;
        exp_q.push_back(mb);
      end
      stall_q   = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  // Caller sits just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [LW-1:0] data, input logic [1:0] mode, input logic [DW-1:0] z,
                      input logic [SW-1:0] s, input logic last);
    int t;
    in_valid = 1'b1;
    in_data  = data;
    mode_in  = mode;
    zero_in  = z;
    scale_in = s;
    in_last  = last;
    for (t = 0; t < 500; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (t == 500) check(1'b0, "accept_timeout", '0, LW'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic single(input logic [DW-1:0] x, input logic [1:0] mode, input logic [DW-1:0] z,
                        input logic [SW-1:0] s, input logic [DW-1:0] exp, input string name);
    int cyc;
    logic [LW-1:0] expv;
    expv = {LN{exp}};
    send({LN{x}}, mode, z, s, 1'b0);
    for (cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check(cyc == 3, {name, "_latency"}, LW'(cyc), LW'(3));
    check(out_data == expv, name, out_data, expv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] data;
    logic [DW-1:0] got_v[4];
    logic          got_l[4];
    int            got;
    int            seen;
    bit            done;

    // Model pins from hand arithmetic.
    check(ref_lane(0, 2, 10, 6554) == 9, "model_leaky_x0", LW'(ref_lane(0, 2, 10, 6554)), LW'(9));
    check(ref_lane(40, 2, 100, 131072) == 0, "model_sat_low", LW'(ref_lane(40, 2, 100, 131072)), '0);
    check(ref_lane(20, 2, 100, 6554) == 92, "model_leaky_x20", LW'(ref_lane(20, 2, 100, 6554)), LW'(92));
    check(ref_lane(3, 1, 10, 0) == 10, "model_relu", LW'(ref_lane(3, 1, 10, 0)), LW'(10));

    // Reset state.
    repeat (2) @(negedge clk);
    check(out_valid == 1'b0, "rst_out_valid", LW'(out_valid), '0);
    check(out_data == '0, "rst_out_data", out_data, '0);
    check(out_last == 1'b0, "rst_out_last", LW'(out_last), '0);
    check(in_ready == 1'b1, "rst_in_ready", LW'(in_ready), LW'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Directed single beats with latency.
    single(8'd0,   2'd2, 8'd10,  18'd6554,   8'd9,   "leaky_x0");
    single(8'd200, 2'd2, 8'd10,  18'd6554,   8'd200, "leaky_x200");
    single(8'd10,  2'd2, 8'd10,  18'd6554,   8'd10,  "leaky_x10");
    single(8'd0,   2'd1, 8'd10,  18'd6554,   8'd10,  "relu_x0");
    single(8'd3,   2'd1, 8'd10,  18'd6554,   8'd10,  "relu_x3");
    single(8'd255, 2'd1, 8'd10,  18'd6554,   8'd255, "relu_x255");
    single(8'd0,   2'd0, 8'd10,  18'd6554,   8'd0,   "bypass_x0");
    single(8'd37,  2'd0, 8'd10,  18'd6554,   8'd37,  "bypass_x37");
    single(8'd37,  2'd3, 8'd10,  18'd6554,   8'd37,  "mode3_x37");
    single(8'd0,   2'd3, 8'd10,  18'd6554,   8'd0,   "mode3_x0");
    single(8'd40,  2'd2, 8'd100, 18'd131072, 8'd0,   "sat_low");
    single(8'd255, 2'd2, 8'd0,   18'd65536,  8'd255, "sat_high");

    // Lane mapping: distinct value per lane, each transformed in place.
    for (int k = 0; k < LN; k++) data[k*DW +: DW] = DW'(20 + k * 30);
    send(data, 2'd2, 8'd100, 18'd6554, 1'b0);
    seen = 0;
    for (int t = 0; t < 10 && !out_valid; t++) @(negedge clk);
    check(out_valid, "lanes_valid", LW'(out_valid), LW'(1));
    check(out_data[DW-1:0] == 8'd92, "lane0_literal", LW'(out_data[DW-1:0]), LW'(92));
    check(out_data[LW-1 -: DW] == 8'd230, "lane7_literal", LW'(out_data[LW-1 -: DW]), LW'(230));
    for (int k = 0; k < LN; k++)
      check(out_data[k*DW +: DW] == DW'(ref_lane(20 + k * 30, 2, 100, 6554)), "lane_map",
            LW'(out_data[k*DW +: DW]), LW'(ref_lane(20 + k * 30, 2, 100, 6554)));
    @(posedge clk);
    #1;

    // Per-beat config: modes 2/1/2/1 back to back, last on the 4th.
    got = 0;
    fork
      begin
        send({LN{8'd0}}, 2'd2, 8'd10, 18'd6554, 1'b0);
        send({LN{8'd0}}, 2'd1, 8'd10, 18'd6554, 1'b0);
        send({LN{8'd0}}, 2'd2, 8'd10, 18'd6554, 1'b0);
        send({LN{8'd0}}, 2'd1, 8'd10, 18'd6554, 1'b1);
      end
      begin
        for (int t = 0; t < 50 && got < 4; t++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            got_v[got] = out_data[DW-1:0];
            got_l[got] = out_last;
            got++;
          end
        end
      end
    join
    check(got == 4, "cfg_count", LW'(got), LW'(4));
    for (int i = 0; i < 4; i++) begin
      check(got_v[i] == ((i % 2 == 0) ? 8'd9 : 8'd10), "cfg_value", LW'(got_v[i]),
            (i % 2 == 0) ? LW'(9) : LW'(10));
      check(got_l[i] == (i == 3), "cfg_last", LW'(got_l[i]), LW'(i == 3));
    end
    @(posedge clk);
    #1;

    // Backpressure: stream with out_ready held low until the pipe is full.
    out_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          for (int k = 0; k < LN; k++) data[k*DW +: DW] = DW'(b * LN + k);
          send(data, 2'd0, 8'd0, 18'd0, 1'b0);
        end
      end
      begin
        repeat (6) @(negedge clk);
        check(in_ready == 1'b0, "bp_in_ready", LW'(in_ready), '0);
        check(out_valid == 1'b1, "bp_out_valid", LW'(out_valid), LW'(1));
        check(exp_q.size() == 3, "bp_in_flight", LW'(exp_q.size()), LW'(3));
        check(out_data[DW-1:0] == 8'd0, "bp_head", LW'(out_data[DW-1:0]), '0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    check(exp_q.size() == 0, "bp_drain", LW'(exp_q.size()), '0);
    @(posedge clk);
    #1;

    // Randomised traffic with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 300; b++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          for (int k = 0; k < LN; k++) data[k*DW +: DW] = DW'($urandom_range(0, 255));
          send(data, 2'($urandom_range(0, 3)), DW'($urandom_range(0, 255)),
               SW'($urandom_range(0, (1 << SW) - 1)), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    check(exp_q.size() == 0, "rand_drain", LW'(exp_q.size()), '0);
    @(posedge clk);
    #1;

    // Reset with beats in flight.
    out_ready = 1'b0;
    send({LN{8'd55}}, 2'd0, 8'd0, 18'd0, 1'b1);
    send({LN{8'd66}}, 2'd0, 8'd0, 18'd0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check(out_valid == 1'b0, "midrst_out_valid", LW'(out_valid), '0);
    check(out_data == '0, "midrst_out_data", out_data, '0);
    check(out_last == 1'b0, "midrst_out_last", LW'(out_last), '0);
    check(in_ready == 1'b1, "midrst_in_ready", LW'(in_ready), LW'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(seen == 0, "no_stale_beat", LW'(seen), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_leakyrelu_pipe.md
Name: image_leakyrelu_pipe

Overview:
- Parametrised, handshaked successor to the per-lane LeakyReLU stage. Sits between the requantisation output and the output-write FIFO in the image conv path.
- Processes PICTURE_NUM*CH_OUT_NUM quantised lanes per beat. Each lane goes through: zero-point subtract -> activation (bypass / ReLU / LeakyReLU with programmable Q-format slope) -> zero-point add -> saturate.
- 3-stage valid/ready pipeline with full-pipe stall; per-beat sampled config; `last` passthrough.

Parameters:
- PICTURE_NUM, 1, pictures processed in parallel
- CH_OUT_NUM, 8, output channels per picture per beat
- DATA_W, 8, unsigned quantised lane width
- SCALE_W, 18, unsigned slope width
- SHIFT, 16, fractional bits of slope (1.0 = 2^SHIFT)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_data  in  LANES*DATA_W  LANES = PICTURE_NUM*CH_OUT_NUM; lane k at [(k+1)*DATA_W-1 : k*DATA_W], k = j*PICTURE_NUM+i (channel j, picture i)
- in_last  in  1  end-of-tile marker, passed through
- mode_in  in  2  0 bypass, 1 ReLU, 2 LeakyReLU, 3 treated as bypass
- zero_in  in  DATA_W  zero point z (unsigned)
- scale_in  in  SCALE_W  negative-side slope, unsigned Q(SHIFT)
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*DATA_W  same lane layout as in_data
- out_last  out  1  aligned with out_data

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n: all stage valid bits, out_valid, out_data and out_last reset to 0. in_ready is 1 during and after reset. Reset mid-stream discards all in-flight beats.
- Advance enable: adv = !v3 || out_ready, where v3 is the stage-3 valid.
  - in_ready = adv (combinational, no comb path from in_valid).
  - On adv, every stage shifts: v1 <= in_valid, v2 <= v1, v3 <= v2.
  - When adv = 0, all stages hold.
  - Bubbles are not collapsed.
- A beat is accepted iff in_valid && in_ready. mode_in, zero_in, scale_in and in_last are sampled with that beat and carried down the pipe, so a config change affects only later beats.
- S1, per lane: d = {1'b0,x} - {1'b0,z}, signed DATA_W+1.
- S2, per lane:
  - If d >= 0, or mode is bypass/3: a = d.
  - If mode is ReLU and d < 0: a = 0.
  - If mode is LeakyReLU and d < 0: p = d * $signed({1'b0,scale}), signed DATA_W+SCALE_W+2; a = (p + 2^(SHIFT-1)) >>> SHIFT. This is arithmetic shift, i.e. round-half-up.
  - a is held at full width; no truncation.
- S3, per lane: r = a + z. If r < 0, out = 0. If r > 2^DATA_W-1, out = 2^DATA_W-1. Otherwise out = r[DATA_W-1:0].
- Bypass returns x exactly, since d + z = x.
- Latency: exactly 3 cycles from acceptance to out_valid with no backpressure. Throughput is 1 beat/cycle.
- out_data/out_last are stable while out_valid && !out_ready. They are updated only on adv.
- Simultaneous in-accept and out-handshake in the same cycle is a normal shift. Full pipe (3 beats) with out_ready = 0 forces in_ready = 0.
- All lanes are independent and identical; the lane count is any value >= 1.

Test Plan:
- Leaky, z=10, scale=6554 (~0.1), defaults -> x=0 gives out 9 (d=-10, p=-65540, (p+32768)>>>16 = -1); x=200 gives 200; x=10 gives 10; latency exactly 3 cycles.
- ReLU, z=10 -> x=0 gives 10; x=3 gives 10; x=255 gives 255. Bypass (mode 0 and 3) -> x=0 gives 0, x=37 gives 37.
- Saturation: leaky, z=100, scale=131072 (2.0) -> x=40 gives 0 (-120+100 clamps). Leaky, z=0, scale=65536 -> x=255 gives 255.
- Backpressure: in_valid=1 continuously with incrementing lane data, out_ready low for 5 cycles -> exactly 3 beats in flight, in_ready=0, out_data stable; on release, sequence is in order with no loss or duplication.
- Per-beat config: alternate mode 2/1 on consecutive beats with x=0, z=10, scale=6554 -> outputs alternate 9/10 in order. in_last on the 4th beat appears on out_last with the 4th output only.
- Lane mapping and reset: PICTURE_NUM=2, CH_OUT_NUM=4, distinct value per lane -> each lane is transformed in place. Assert rst_n low with 2 beats in flight -> out_valid=0 and out_data=0 immediately; after release, no stale beat emerges.
